// File: rtl/emergency_preempt_conditioner.sv
// rtl/emergency_preempt_conditioner.sv - conditions the emergency preemption sensor and operator override into one request
module emergency_preempt_conditioner #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int MIN_HOLD_CYCLES   = 64,
  parameter int MAX_ACTIVE_CYCLES = 1024,
  parameter int LOCKOUT_CYCLES    = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        sensor_raw,
  input  logic        manual_override,
  output logic        emergency_vehicle,
  output logic        lockout,
  output logic        timeout_pulse,
  output logic [15:0] event_count
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW = $clog2(MAX_ACTIVE_CYCLES + 1);
  localparam int LW = (LOCKOUT_CYCLES < 1) ? 1 : $clog2(LOCKOUT_CYCLES + 1);

  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW-1:0] MIN_A    = AW'(MIN_HOLD_CYCLES);
  localparam logic [AW-1:0] MAX_A    = AW'(MAX_ACTIVE_CYCLES);
  localparam logic [LW-1:0] LOCK_N   = LW'(LOCKOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_QUALIFY = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_LOCKOUT = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [DW-1:0]          deb_q, deb_d;
  logic [AW-1:0]          act_q, act_d;
  logic [LW-1:0]          lock_q, lock_d;
  logic [15:0]            evt_q, evt_d;
  logic                   tp_q, tp_d;
  logic                   sensor_q;
  logic                   req;

  assign sensor_q = sync_q[SYNC_STAGES-1] & enable;
  assign req      = sensor_q | manual_override;

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], sensor_raw};
    state_d = state_q;
    deb_d   = deb_q;
    act_d   = act_q;
    lock_d  = lock_q;
    evt_d   = evt_q;
    tp_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (sensor_q) begin
          // The cycle that first sees the sensor high counts as debounce cycle one.
          if (DEBOUNCE_CYCLES == 1) begin
            state_d = ST_ACTIVE;
          end else begin
            state_d = ST_QUALIFY;
            deb_d   = DW'(1);
          end
        end
      end
      ST_QUALIFY: begin
        if (!sensor_q) begin
          state_d = ST_IDLE;
          deb_d   = '0;
        end else if (deb_q >= DEB_LAST) begin
          state_d = ST_ACTIVE;
        end else begin
          deb_d = deb_q + DW'(1);
        end
      end
      ST_ACTIVE: begin
        if (!req && act_q >= MIN_A) begin
          state_d = ST_IDLE;
        end else if (!manual_override && act_q == MAX_A) begin
          state_d = ST_LOCKOUT;
        end else if (act_q != MAX_A) begin
          act_d = act_q + AW'(1);
        end
      end
      ST_LOCKOUT: begin
        if (lock_q >= LOCK_N && !sensor_q) begin
          state_d = ST_IDLE;
        end else if (lock_q < LOCK_N) begin
          lock_d = lock_q + LW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (manual_override && state_q != ST_ACTIVE) begin
      state_d = ST_ACTIVE;
    end

    // Entry bookkeeping is shared by the sensor and override paths.
    if (state_d == ST_ACTIVE && state_q != ST_ACTIVE) begin
      act_d = AW'(1);
      deb_d = '0;
      if (evt_q != 16'hFFFF) begin
        evt_d = evt_q + 16'd1;
      end
    end
    if (state_d == ST_LOCKOUT && state_q != ST_LOCKOUT) begin
      lock_d = LW'(1);
      tp_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sync_q  <= '0;
      deb_q   <= '0;
      act_q   <= '0;
      lock_q  <= '0;
      evt_q   <= '0;
      tp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      deb_q   <= deb_d;
      act_q   <= act_d;
      lock_q  <= lock_d;
      evt_q   <= evt_d;
      tp_q    <= tp_d;
    end
  end

  assign emergency_vehicle = (state_q == ST_ACTIVE);
  assign lockout           = (state_q == ST_LOCKOUT);
  assign timeout_pulse     = tp_q;
  assign event_count       = evt_q;

endmodule

// File: doc/emergency_preempt_conditioner.md
Name: emergency_preempt_conditioner

Overview:
- Upstream conditioner for the intersection controller's emergency_vehicle input.
- Converts an asynchronous, noisy preemption sensor (optical/siren detector) and a synchronous operator override into one clean, registered request.
- Provides debounce, a minimum hold time, a maximum-active timeout with post-timeout lockout (stuck-sensor protection), and a saturating event counter.

Parameters:
- SYNC_STAGES, 2, synchronizer flop count on sensor_raw (min 2).
- DEBOUNCE_CYCLES, 16, consecutive synchronized-high cycles required to qualify a sensor request (min 1).
- MIN_HOLD_CYCLES, 64, minimum emergency_vehicle high width, in cycles.
- MAX_ACTIVE_CYCLES, 1024, maximum sensor-only high width before timeout (must be > MIN_HOLD_CYCLES).
- LOCKOUT_CYCLES, 256, minimum cycles ignoring the sensor after a timeout.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  sync; 0 blocks the sensor path only.
- sensor_raw  in  1  async raw preemption detector.
- manual_override  in  1  sync operator force; bypasses debounce and timeout.
- emergency_vehicle  out  1  registered conditioned request to the light controller.
- lockout  out  1  registered; high while in LOCKOUT.
- timeout_pulse  out  1  registered one-cycle pulse on timeout.
- event_count  out  16  registered saturating count of ACTIVE entries.

Behaviour:
- Reset (async, any time, including mid-ACTIVE):
  - state = IDLE; all outputs 0; all counters 0; synchronizer flops 0.
  - Takes effect immediately; no hold completion.
- sensor_s is the SYNC_STAGES-deep synchronized sensor_raw.
- sensor_q = sensor_s AND enable.
- States: IDLE, QUALIFY, ACTIVE, LOCKOUT.
- Priority in every state: reset > manual_override > all other transitions.
- manual_override sampled 1 in IDLE, QUALIFY or LOCKOUT: next state ACTIVE, so emergency_vehicle = 1 after exactly one edge.
- IDLE:
  - sensor_q = 1 → QUALIFY; debounce count starts.
- QUALIFY:
  - sensor_q = 0 on any cycle → IDLE; count discarded.
  - sensor_q held high → ACTIVE.
  - Sensor-path latency: emergency_vehicle rises exactly SYNC_STAGES + DEBOUNCE_CYCLES edges after the first edge sampling sensor_raw = 1, given sensor_raw is held (defaults: 18).
- ACTIVE:
  - emergency_vehicle = 1.
  - active_cnt = 1 on the entry edge, +1 per cycle; it saturates at MAX_ACTIVE_CYCLES.
  - req = sensor_q OR manual_override.
  - Release → IDLE: at the first edge where req = 0 and active_cnt ≥ MIN_HOLD_CYCLES. High width is therefore ≥ MIN_HOLD_CYCLES.
  - Timeout: if manual_override = 0 and active_cnt = MAX_ACTIVE_CYCLES → LOCKOUT. High width is exactly MAX_ACTIVE_CYCLES; timeout_pulse = 1 for the one cycle lockout first reads 1.
  - manual_override = 1: never times out; the hold rule still applies after it drops.
  - Release and timeout on the same edge: release wins.
- LOCKOUT:
  - emergency_vehicle = 0; lockout = 1.
  - lock_cnt counts LOCKOUT_CYCLES.
  - → IDLE at the first edge where lock_cnt is done and sensor_q = 0; a stuck sensor holds LOCKOUT indefinitely.
- enable:
  - Deasserted in QUALIFY → IDLE.
  - Deasserted in ACTIVE: treated as sensor dropping (the hold rule applies).
- event_count: +1 on each transition into ACTIVE; saturates at 16'hFFFF.
- Re-entry: an ACTIVE → IDLE → QUALIFY re-entry needs the full debounce again; there is no fast path.
- Output encoding: all outputs are state-decoded from flops (no combinational path from inputs). emergency_vehicle is never high in any state other than ACTIVE.

Test Plan:
- Reset, then sensor_raw = 1 for 10 cycles → emergency_vehicle stays 0; event_count = 0.
- sensor_raw high 20 cycles, then low → emergency_vehicle rises at edge 18, stays high exactly 64 cycles; event_count = 1.
- sensor_raw high 2000 cycles → high at edge 18, falls after exactly 1024 cycles with timeout_pulse = 1 for one cycle.
  - lockout then stays 1 until sensor_raw is released.
  - After release, IDLE is reached no earlier than 256 cycles after the timeout.
- In LOCKOUT, pulse manual_override for 1 cycle → emergency_vehicle = 1 next edge, held 64 cycles; lockout = 0; event_count increments.
- manual_override held 3000 cycles → emergency_vehicle continuous high, no timeout_pulse; falls 1 edge after override drops.
- rst_n asserted mid-ACTIVE (cycle 30) → all outputs 0 immediately; after release, a new 18-cycle qualification is required.
